// File: rtl/gates_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gates_seq_ctrl_if
// Description : Bundle of the control, operand and result signals exchanged
//               between the gate-block sequencer and its environment.
//               slave  - sequencer side (gates_seq_ctrl)
//               master - environment side (host / gate block / testbench)
// Signals     : start, step_mode, step  - sequencing controls
//               res_in[5:0]             - gate results AND,OR,NAND,NOR,XOR,XNOR
//               a, b                    - operands to the gate block
//               res_out[5:0], vec_idx   - latched result, current vector
//               busy, done, pass        - status
//               err_cnt[2:0]            - mismatched vectors this run
// Revision    : 1.0 - initial release
// ============================================================================
interface gates_seq_ctrl_if;
  logic       start;
  logic       step_mode;
  logic       step;
  logic [5:0] res_in;
  logic       a;
  logic       b;
  logic [5:0] res_out;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;

  modport slave (
    input  start, step_mode, step, res_in,
    output a, b, res_out, vec_idx, busy, done, pass, err_cnt
  );

  modport master (
    output start, step_mode, step, res_in,
    input  a, b, res_out, vec_idx, busy, done, pass, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/gates_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gates_seq_ctrl
// Description : Self-test sequencer for a two-input logic-gate block. Walks
//               {a,b} through 00,01,10,11, samples the gate results after a
//               settle delay, checks them against the truth table, holds each
//               vector for a dwell (auto) or until a step pulse (step mode),
//               and reports err_cnt / pass / done.
// Ports       : clk      - system clock
//               rst      - synchronous, active-high reset
//               bus      - gates_seq_ctrl_if.slave (controls, operands,
//                          results and status)
// Parameters  : DWELL_CYCLES  - cycles each vector is held after its check
//               SETTLE_CYCLES - cycles from driving a/b to sampling res_in
//               CNT_W         - dwell/settle counter width
// Build option: GATES_SEQ_LOOP_EN - when defined, auto mode loops forever,
//               pulsing done and updating pass at the end of every pass.
// Revision    : 1.0 - initial release
// ============================================================================
module gates_seq_ctrl #(
  parameter int DWELL_CYCLES  = 12000000,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 24
) (
  input  wire logic         clk,
  input  wire logic         rst,
  gates_seq_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DWELL  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step_mode;
  logic             r_a;
  logic             r_b;
  logic [5:0]       r_res;
  logic [1:0]       r_idx;
  logic [2:0]       r_err;
  logic             r_pass;
  logic             r_done;

  logic [5:0]       w_expected;
  logic             w_mismatch;
  logic             w_dwell_exit;
  logic             w_last;
  logic             w_wrap;

  // Truth table for the operands currently applied to the gate block.
  assign w_expected = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), ~(r_a & r_b),
                       r_a | r_b, r_a & r_b};
  assign w_mismatch = (bus.res_in != w_expected);

  // Leaving DWELL: step pulse in step mode, counter expiry otherwise.
  assign w_dwell_exit = (r_state == S_DWELL) &&
                        (r_step_mode ? bus.step : (r_cnt == '0));
  assign w_last       = w_dwell_exit && (r_idx == 2'd3);

`ifdef GATES_SEQ_LOOP_EN
  // Auto mode restarts at vector 0 instead of stopping; step mode never loops.
  assign w_wrap = w_last && !r_step_mode;
`else
  assign w_wrap = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE:  w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK:  w_state_nxt = S_DWELL;
      S_DWELL: begin
        if (w_dwell_exit) begin
          w_state_nxt = (w_last && !w_wrap) ? S_DONE : S_DRIVE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: operands, counter, result latch and scoring
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_step_mode <= 1'b0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_res       <= 6'd0;
      r_idx       <= 2'd0;
      r_err       <= 3'd0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_err       <= 3'd0;
            r_pass      <= 1'b0;
            r_idx       <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_step_mode <= bus.step_mode;
          end
        end
        S_DRIVE: begin
          {r_a, r_b} <= r_idx;
          r_cnt      <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          r_res <= bus.res_in;
          if (w_mismatch && (r_err != 3'd4)) begin
            r_err <= r_err + 3'd1;
          end
          r_cnt <= DWELL_LOAD;
        end
        S_DWELL: begin
          if (!r_step_mode && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (w_dwell_exit) begin
            if (w_last) begin
              // err_cnt already includes the last vector's check here.
              r_done <= 1'b1;
              r_pass <= (r_err == 3'd0);
              if (w_wrap) begin
                r_err <= 3'd0;
                r_idx <= 2'd0;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.a       = r_a;
    bus.b       = r_b;
    bus.res_out = r_res;
    bus.vec_idx = r_idx;
    bus.busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    bus.done    = r_done;
    bus.pass    = r_pass;
    bus.err_cnt = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_gates_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gates_seq_ctrl
// Description : Self-checking bench for gates_seq_ctrl (SETTLE=2, DWELL=5).
//               A phase-based reference model predicts every output each
//               cycle; directed scenarios add hand-computed literal checks.
//               Build with GATES_SEQ_LOOP_EN to exercise the looping option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gates_seq_ctrl;

  localparam int SET = 2;
  localparam int DW  = 5;
`ifdef GATES_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck_xor = 1'b0;
  logic cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t0;

  gates_seq_ctrl_if bus ();

  gates_seq_ctrl #(
    .DWELL_CYCLES (DW),
    .SETTLE_CYCLES(SET),
    .CNT_W        (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Ideal gate block: [0]AND [1]OR [2]NAND [3]NOR [4]XOR [5]XNOR
  function automatic logic [5:0] gate(input logic a, input logic b);
    logic [5:0] g;
    g[0] = a & b;
    g[1] = a | b;
    g[2] = ~(a & b);
    g[3] = ~(a | b);
    g[4] = a ^ b;
    g[5] = ~(a ^ b);
    return g;
  endfunction

  always_comb bus.res_in = gate(bus.a, bus.b) & (stuck_xor ? 6'b101111 : 6'b111111);

  // -------------------------------------------------------------------------
  // Reference model: t counts cycles into the current vector
  // (0 = operands applied, 1..SET settling, SET+1 sample, then dwell).
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic       active;
    int         t;
    logic [1:0] idx;
    logic       a;
    logic       b;
    logic [5:0] res;
    logic [2:0] err;
    logic       pass;
    logic       done;
    logic       smode;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t model_step(input mdl_t m, input logic r, input logic st,
                                      input logic sm, input logic sp, input logic stk);
    mdl_t       n;
    logic [5:0] good;
    logic [5:0] seen;
    logic       leave;
    n = m;
    n.done = 1'b0;
    if (r) begin
      n = '0;
    end else if (!m.active) begin
      if (st) begin
        n.active = 1'b1;
        n.t      = 0;
        n.idx    = 2'd0;
        n.a      = 1'b0;
        n.b      = 1'b0;
        n.err    = 3'd0;
        n.pass   = 1'b0;
        n.smode  = sm;
      end
    end else begin
      if (m.t == 0) {n.a, n.b} = m.idx;
      if (m.t == SET + 1) begin
        good  = gate(m.a, m.b);
        seen  = stk ? (good & 6'b101111) : good;
        n.res = seen;
        if (seen != good && m.err < 3'd4) n.err = m.err + 3'd1;
      end
      leave = (m.t >= SET + 2) && (m.smode ? sp : (m.t == SET + 1 + DW));
      if (leave) begin
        if (m.idx == 2'd3) begin
          n.done = 1'b1;
          n.pass = (m.err == 3'd0);
          if (LOOP && !m.smode) begin
            n.idx = 2'd0;
            n.t   = 0;
            n.err = 3'd0;
          end else begin
            n.active = 1'b0;
          end
        end else begin
          n.idx = m.idx + 2'd1;
          n.t   = 0;
        end
      end else if (m.t < 100000) begin
        n.t = m.t + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mdl <= model_step(mdl, rst, bus.start, bus.step_mode, bus.step, stuck_xor);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_a",       32'(bus.a),       32'(mdl.a));
      chk("m_b",       32'(bus.b),       32'(mdl.b));
      chk("m_res_out", 32'(bus.res_out), 32'(mdl.res));
      chk("m_vec_idx", 32'(bus.vec_idx), 32'(mdl.idx));
      chk("m_busy",    32'(bus.busy),    32'(mdl.active));
      chk("m_done",    32'(bus.done),    32'(mdl.done));
      chk("m_pass",    32'(bus.pass),    32'(mdl.pass));
      chk("m_err_cnt", 32'(bus.err_cnt), 32'(mdl.err));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // start is high during cycle 0; on return we are in cycle 1.
  task automatic pulse_start(input logic sm, input logic with_step);
    bus.step_mode = sm;
    bus.start     = 1'b1;
    bus.step      = with_step;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.step      = 1'b0;
    bus.step_mode = 1'b0;
    cyc = 1;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    while (bus.done !== 1'b1 && cyc < limit) tick(1);
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ab"},      32'({bus.a, bus.b}), 32'd0);
    chk({tag, "_res_out"}, 32'(bus.res_out),    32'd0);
    chk({tag, "_vec_idx"}, 32'(bus.vec_idx),    32'd0);
    chk({tag, "_busy"},    32'(bus.busy),       32'd0);
    chk({tag, "_done"},    32'(bus.done),       32'd0);
    chk({tag, "_pass"},    32'(bus.pass),       32'd0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt),    32'd0);
  endtask

  logic [5:0] exp_res [4];

  initial begin
    exp_res[0] = 6'b101100;
    exp_res[1] = 6'b010110;
    exp_res[2] = 6'b010110;
    exp_res[3] = 6'b100011;
    bus.start = 1'b0;
    bus.step = 1'b0;
    bus.step_mode = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk_reset_vals("reset");

`ifndef GATES_SEQ_LOOP_EN
    // Clean auto pass: result latched at cycle 5+9k for vector k.
    pulse_start(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(5 + 9 * k - cyc);
      chk("auto_res_out", 32'(bus.res_out), 32'(exp_res[k]));
      chk("auto_ab", 32'({bus.a, bus.b}), 32'(k));
    end
    wait_done(100);
    chk("auto_latency", 32'(cyc), 32'd37);
    chk("auto_pass", 32'(bus.pass), 32'd1);
    chk("auto_err", 32'(bus.err_cnt), 32'd0);
    tick(1);
    chk("auto_done_pulse", 32'(bus.done), 32'd0);
    chk("auto_idle", 32'(bus.busy), 32'd0);

    // XOR output stuck at 0: vectors 01 and 10 fail.
    stuck_xor = 1'b1;
    pulse_start(1'b0, 1'b0);
    wait_done(100);
    chk("fault_latency", 32'(cyc), 32'd37);
    chk("fault_err", 32'(bus.err_cnt), 32'd2);
    chk("fault_pass", 32'(bus.pass), 32'd0);

    // start while busy on vector 1 (after its check) is ignored.
    pulse_start(1'b0, 1'b0);
    tick(16 - cyc);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("busy_start_err", 32'(bus.err_cnt), 32'd1);
    chk("busy_start_idx", 32'(bus.vec_idx), 32'd1);
    wait_done(100);
    chk("busy_start_latency", 32'(cyc), 32'd37);
    chk("busy_start_err_end", 32'(bus.err_cnt), 32'd2);
    stuck_xor = 1'b0;
    tick(2);
`endif

    // Step mode, with a step in the same cycle as start (dropped).
    pulse_start(1'b1, 1'b1);
    tick(50);
    chk("step_busy", 32'(bus.busy), 32'd1);
    chk("step_hold_ab", 32'({bus.a, bus.b}), 32'd0);
    chk("step_hold_idx", 32'(bus.vec_idx), 32'd0);
    chk("step_hold_res", 32'(bus.res_out), 32'(exp_res[0]));
    pulse_step();
    chk("step1_idx", 32'(bus.vec_idx), 32'd1);
    tick(1);
    pulse_step();                 // lands in SETTLE: ignored
    tick(10);
    chk("step_settle_ignored", 32'(bus.vec_idx), 32'd1);
    chk("step1_ab", 32'({bus.a, bus.b}), 32'd1);
    for (int k = 2; k < 4; k++) begin
      pulse_step();
      tick(10);
      chk("stepk_idx", 32'(bus.vec_idx), 32'(k));
    end
    pulse_step();
    chk("step4_done", 32'(bus.done), 32'd1);
    chk("step4_pass", 32'(bus.pass), 32'd1);
    tick(1);
    chk("step4_idle", 32'(bus.busy), 32'd0);
    pulse_step();                 // in DONE: ignored
    tick(3);
    chk("step_done_ignored", 32'(bus.busy), 32'd0);

    // Reset for one cycle in the middle of vector 2's settle.
    pulse_start(1'b0, 1'b0);
    tick(20 - cyc);
    chk("rst_pre_idx", 32'(bus.vec_idx), 32'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset_vals("midrst");
    tick(3);
    chk("midrst_stays_idle", 32'(bus.busy), 32'd0);
    pulse_start(1'b0, 1'b0);
    wait_done(100);
    chk("midrst_latency", 32'(cyc), 32'd37);
    chk("midrst_pass", 32'(bus.pass), 32'd1);
    chk("midrst_err", 32'(bus.err_cnt), 32'd0);

`ifdef GATES_SEQ_LOOP_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pulse_start(1'b0, 1'b0);
    wait_done(100);
    chk("loop_first_latency", 32'(cyc), 32'd37);
    chk("loop_busy", 32'(bus.busy), 32'd1);
    chk("loop_wrap_idx", 32'(bus.vec_idx), 32'd0);
    chk("loop_pass", 32'(bus.pass), 32'd1);
    t0 = cyc;
    tick(1);
    wait_done(t0 + 60);
    chk("loop_period", 32'(cyc - t0), 32'd36);
    chk("loop_busy2", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
